// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/response handshake bundle for the MEM-stage access controller
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store front end for a big-endian byte-addressed data memory
module mem_access_ctrl #(
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        rst,
  mem_access_ctrl_if.slave bus,
  output logic [31:0] dm_address,
  output logic [31:0] dm_write_data,
  input  logic [31:0] dm_read_data,
  output logic        dm_MemRead,
  output logic        dm_MemWrite
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR, S_RESP
  } state_e;

  localparam logic [31:0] LAST_BASE = 32'(MEM_BYTES - 4);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic        rd_c, wr_c, ready_c;
  logic [31:0] wdata_c, addr_c, base_req;
  logic [1:0]  req_err_c;

  // Big-endian lanes: byte offset 0 is the most significant byte.
  function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [31:0] d,
                                             input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end else if (sz == 2'b01) begin
      if (off[1]) r[15:0] = d[15:0];
      else        r[31:16] = d[15:0];
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    if (sz == 2'b00)      return {{24{sgn & b[7]}}, b};
    else if (sz == 2'b01) return {{16{sgn & h[15]}}, h};
    else                  return w;
  endfunction

  assign base_req = {bus.req_addr[31:2], 2'b00};

  always_comb begin
    req_err_c = 2'b00;
    if ((bus.req_size == 2'b11) ||
        (bus.req_size == 2'b01 && bus.req_addr[0]) ||
        (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00))
      req_err_c = 2'b01;
    else if (base_req > LAST_BASE)
      req_err_c = 2'b10;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rd_c     = 1'b0;
    wr_c     = 1'b0;
    ready_c  = 1'b0;
    wdata_c  = 32'h0;
    addr_c   = 32'h0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'h0;
    bus.resp_err   = 2'b00;
    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          wdata_d  = bus.req_wdata;
          err_d    = req_err_c;
          rdata_d  = 32'h0;
          if (req_err_c != 2'b00)       state_d = S_RESP;
          else if (!bus.req_write)      state_d = S_LOAD;
          else if (bus.req_size == 2'b10) state_d = S_STORE;
          else                          state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        rd_c    = 1'b1;
        addr_c  = {addr_q[31:2], 2'b00};
        rdata_d = load_extend(dm_read_data, size_q, addr_q[1:0], signed_q);
        state_d = S_RESP;
      end
      S_STORE: begin
        wr_c    = 1'b1;
        addr_c  = {addr_q[31:2], 2'b00};
        wdata_c = wdata_q;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        rd_c    = 1'b1;
        addr_c  = {addr_q[31:2], 2'b00};
        word_d  = dm_read_data;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: begin
        wr_c    = 1'b1;
        addr_c  = {addr_q[31:2], 2'b00};
        wdata_c = lane_merge(word_q, wdata_q, size_q, addr_q[1:0]);
        state_d = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A write cycle overlapping reset must not reach the memory.
  assign bus.req_ready  = ready_c & ~rst;
  assign dm_MemRead     = rd_c;
  assign dm_MemWrite    = wr_c & ~rst;
  assign dm_address     = addr_c;
  assign dm_write_data  = dm_MemWrite ? wdata_c : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'h0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      wdata_q  <= 32'h0;
      word_q   <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] dm_address;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;
  logic        dm_MemRead;
  logic        dm_MemWrite;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.MEM_BYTES(16384)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .dm_address    (dm_address),
    .dm_write_data (dm_write_data),
    .dm_read_data  (dm_read_data),
    .dm_MemRead    (dm_MemRead),
    .dm_MemWrite   (dm_MemWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [0:16383];
  logic [13:0] ma;

  always_comb begin
    ma = dm_address[13:0];
    dm_read_data = {mem[ma], mem[ma + 14'd1], mem[ma + 14'd2], mem[ma + 14'd3]};
  end

  always @(posedge clk) begin
    if (dm_MemWrite) begin
      mem[dm_address[13:0]]         <= dm_write_data[31:24];
      mem[dm_address[13:0] + 14'd1] <= dm_write_data[23:16];
      mem[dm_address[13:0] + 14'd2] <= dm_write_data[15:8];
      mem[dm_address[13:0] + 14'd3] <= dm_write_data[7:0];
    end
  end

  function automatic logic [31:0] mword(input int a);
    return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
  endfunction

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  int          t_lat;
  logic        t_ready, t_rd, t_wr;
  logic [31:0] t_rdata;
  logic [1:0]  t_err;

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    #1 t_ready = bus.req_ready;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    t_lat = 1;
    t_rd  = 1'b0;
    t_wr  = 1'b0;
    while (!bus.resp_valid && t_lat < 8) begin
      t_rd = t_rd | dm_MemRead;
      t_wr = t_wr | dm_MemWrite;
      @(negedge clk);
      t_lat++;
    end
    if (!bus.resp_valid) t_lat = 99;
    t_rdata = bus.resp_rdata;
    t_err   = bus.resp_err;
  endtask

  logic seen_resp;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[16'h00FF] = 8'h5A;
    mem[16'h0104] = 8'hA5;
    {mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203]} = 32'hCAFED00D;
    {mem[16'h3FFC], mem[16'h3FFD], mem[16'h3FFE], mem[16'h3FFF]} = 32'hDEADBEEF;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_dm_address", dm_address, 32'h0);
    chk("rst_dm_write", 32'(dm_MemWrite), 32'h0);
    rst = 1'b0;
    #1 chk("idle_ready", 32'(bus.req_ready), 32'h1);

    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344);
    chk("sw_ready", 32'(t_ready), 32'h1);
    chk("sw_lat", 32'(t_lat), 32'd2);
    chk("sw_err", 32'(t_err), 32'h0);
    chk("sw_rdata", t_rdata, 32'h0);
    chk("sw_mem", mword(32'h100), 32'h11223344);
    chk("sw_mem_byte0", 32'(mem[16'h100]), 32'h11);
    @(negedge clk);
    chk("resp_clear_valid", 32'(bus.resp_valid), 32'h0);

    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    chk("lw_lat", 32'(t_lat), 32'd2);
    chk("lw_rdata", t_rdata, 32'h11223344);
    @(negedge clk);
    chk("resp_clear_rdata", bus.resp_rdata, 32'h0);

    issue(1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFFFFAB);
    chk("sb_lat", 32'(t_lat), 32'd3);
    chk("sb_mem", mword(32'h100), 32'h11AB3344);
    chk("sb_neigh_lo", 32'(mem[16'h00FF]), 32'h5A);
    chk("sb_neigh_hi", 32'(mem[16'h0104]), 32'hA5);

    issue(1'b0, 2'b00, 1'b1, 32'h101, 32'h0);
    chk("lb_rdata", t_rdata, 32'hFFFFFFAB);
    issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0);
    chk("lbu_rdata", t_rdata, 32'h000000AB);

    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h7F028001);
    issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
    chk("lh2_signed", t_rdata, 32'hFFFF8001);
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    chk("lhu2", t_rdata, 32'h00008001);
    issue(1'b0, 2'b01, 1'b1, 32'h100, 32'h0);
    chk("lh0_signed_pos", t_rdata, 32'h00007F02);
    issue(1'b0, 2'b00, 1'b1, 32'h102, 32'h0);
    chk("lb2_signed", t_rdata, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    chk("lbu3", t_rdata, 32'h00000001);

    issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    chk("lw_mis_err", 32'(t_err), 32'h1);
    chk("lw_mis_lat", 32'(t_lat), 32'd1);
    chk("lw_mis_noread", 32'(t_rd), 32'h0);
    chk("lw_mis_rdata", t_rdata, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    chk("size11_err", 32'(t_err), 32'h1);
    issue(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
    chk("lh_odd_err", 32'(t_err), 32'h1);

    issue(1'b1, 2'b10, 1'b0, 32'h4000, 32'h12345678);
    chk("sw_oor_err", 32'(t_err), 32'h2);
    chk("sw_oor_nowrite", 32'(t_wr), 32'h0);
    chk("sw_oor_mem0", mword(0), 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0);
    chk("lw_last_err", 32'(t_err), 32'h0);
    chk("lw_last_rdata", t_rdata, 32'hDEADBEEF);
    issue(1'b0, 2'b00, 1'b1, 32'h3FFF, 32'h0);
    chk("lb_last_rdata", t_rdata, 32'hFFFFFFEF);
    issue(1'b0, 2'b00, 1'b0, 32'h4000, 32'h0);
    chk("lb_oor_err", 32'(t_err), 32'h2);
    issue(1'b0, 2'b10, 1'b0, 32'h4002, 32'h0);
    chk("mis_before_oor", 32'(t_err), 32'h1);

    issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF);
    chk("sh_lat", 32'(t_lat), 32'd3);
    chk("sh_mem", mword(32'h200), 32'hCAFEBEEF);

    // Reset lands in the RMW write cycle; the store must be dropped.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
    bus.req_signed = 1'b0; bus.req_addr = 32'h200; bus.req_wdata = 32'h00005555;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_wr_active", 32'(dm_MemWrite), 32'h1);
    rst = 1'b1;
    #1 chk("rmw_wr_forced0", 32'(dm_MemWrite), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen_resp = bus.resp_valid;
    #1 chk("rmw_rst_ready", 32'(bus.req_ready), 32'h1);
    repeat (3) begin
      @(negedge clk);
      seen_resp = seen_resp | bus.resp_valid;
    end
    chk("rmw_rst_noresp", 32'(seen_resp), 32'h0);
    chk("rmw_rst_mem", mword(32'h200), 32'hCAFEBEEF);

    // Two loads with req_valid held high between them.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_busy_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    chk("b2b_first_valid", 32'(bus.resp_valid), 32'h1);
    chk("b2b_first_rdata", bus.resp_rdata, 32'h7F028001);
    chk("b2b_resp_ready", 32'(bus.req_ready), 32'h0);
    bus.req_addr = 32'h3FFC;
    @(negedge clk);
    chk("b2b_second_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_valid", 32'(bus.resp_valid), 32'h1);
    chk("b2b_second_rdata", bus.resp_rdata, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
